// File: rtl/servo_pkg.sv
// Shared types, defaults and the clamp helper for the servo PWM core.
package servo_pkg;

  localparam int CNT_W_DEF        = 24;
  localparam int PULSE_MIN_DEF    = 100000;
  localparam int PULSE_MAX_DEF    = 200000;
  localparam int PULSE_CENTER_DEF = 150000;
  localparam int SLEW_STEP_DEF    = 2000;

  typedef logic [CNT_W_DEF-1:0] pulse_t;

  function automatic pulse_t clamp_pulse(pulse_t value, pulse_t lo, pulse_t hi);
    if (value < lo) return lo;
    else if (value > hi) return hi;
    else return value;
  endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: clamps its target, slew-limits the pulse width once per
// frame and drives a registered PWM pin from the shared next-count value.
module servo_slew_channel
  import servo_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int PULSE_MIN    = PULSE_MIN_DEF,
  parameter int PULSE_MAX    = PULSE_MAX_DEF,
  parameter int PULSE_CENTER = PULSE_CENTER_DEF,
  parameter int SLEW_STEP    = SLEW_STEP_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             boundary,
  input  logic             enable,
  input  logic [CNT_W-1:0] target,
  input  logic [CNT_W-1:0] cnt_next,
  output logic             pwm,
  output logic             at_target
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(SLEW_STEP);

  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] cur_next;
  logic [CNT_W-1:0] diff;
  logic             shadow_en;
  logic             en_next;

  assign tgt = CNT_W'(clamp_pulse(pulse_t'(target), pulse_t'(PULSE_MIN), pulse_t'(PULSE_MAX)));

  always_comb begin
    cur_next = cur;
    en_next  = shadow_en;
    diff     = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    if (boundary) begin
      en_next = enable;
      if ((SLEW_STEP == 0) || (diff <= STEP)) cur_next = tgt;
      else if (tgt > cur)                     cur_next = cur + STEP;
      else                                    cur_next = cur - STEP;
    end
  end

  // Output is computed from next-state values so it changes on the same
  // edge as the frame counter and the shadow registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur       <= CNT_W'(PULSE_CENTER);
      shadow_en <= 1'b0;
      pwm       <= 1'b0;
      at_target <= 1'b0;
    end else begin
      cur       <= cur_next;
      shadow_en <= en_next;
      pwm       <= en_next && (cnt_next < cur_next);
      if (boundary) at_target <= (cur_next == tgt);
    end
  end

endmodule

// File: rtl/servo_pwm_core.sv
// Multi-channel servo PWM generator: frame counter, shadow period and one
// slew-limited channel per servo pin.
module servo_pwm_core
  import servo_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int PULSE_MIN    = PULSE_MIN_DEF,
  parameter int PULSE_MAX    = PULSE_MAX_DEF,
  parameter int PULSE_CENTER = PULSE_CENTER_DEF,
  parameter int SLEW_STEP    = SLEW_STEP_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       reg_enable,
  input  logic [CNT_W-1:0]        reg_period,
  input  logic [NUM_CH*CNT_W-1:0] reg_pulse,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    frame_tick,
  output logic [NUM_CH-1:0]       at_target
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] shadow_period;
  logic             boundary;
  logic             period_nz;

  assign boundary  = (shadow_period == '0) || (cnt == shadow_period - CNT_W'(1));
  assign cnt_next  = boundary ? '0 : cnt + CNT_W'(1);
  // A zero period forces every channel's latched enable low, so all pins
  // stay quiet while the core idles on single-cycle frames.
  assign period_nz = (reg_period != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      shadow_period <= '0;
      frame_tick    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      frame_tick <= boundary;
      if (boundary) shadow_period <= reg_period;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    servo_slew_channel #(
      .CNT_W       (CNT_W),
      .PULSE_MIN   (PULSE_MIN),
      .PULSE_MAX   (PULSE_MAX),
      .PULSE_CENTER(PULSE_CENTER),
      .SLEW_STEP   (SLEW_STEP)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .boundary (boundary),
      .enable   (reg_enable[k] && period_nz),
      .target   (reg_pulse[k*CNT_W +: CNT_W]),
      .cnt_next (cnt_next),
      .pwm      (pwm_out[k]),
      .at_target(at_target[k])
    );
  end

endmodule

// File: tb/tb_servo_pwm_core.sv
// Bench for servo_pwm_core: two instances (no slew / slew 4) share stimulus;
// a frame-level model fills an expected-output queue checked every cycle.
module tb_servo_pwm_core;

  localparam int CNT_W = 24;
  localparam int NCH   = 2;
  localparam int P_MIN = 10;
  localparam int P_MAX = 60;
  localparam int W     = 10;
  localparam int CENTER_A = 35;
  localparam int CENTER_B = 20;
  localparam int SLEW_B   = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH-1:0]       reg_enable;
  logic [CNT_W-1:0]     reg_period;
  logic [NCH*CNT_W-1:0] reg_pulse;
  logic [NCH-1:0]       pwm_a, pwm_b, at_a, at_b;
  logic                 ft_a, ft_b;

  int             nxt_period;
  int             nxt_pulse [NCH];
  logic [NCH-1:0] nxt_en;

  logic [W-1:0] exp_q[$];
  int           model_cur [2][NCH];
  int           frame_len;
  int           last_pos;
  int           errors = 0;
  int           checks = 0;

  servo_pwm_core #(
    .NUM_CH(NCH), .CNT_W(CNT_W), .PULSE_MIN(P_MIN), .PULSE_MAX(P_MAX),
    .PULSE_CENTER(CENTER_A), .SLEW_STEP(0)
  ) dut_a (
    .clock(clock), .reset(reset), .reg_enable(reg_enable), .reg_period(reg_period),
    .reg_pulse(reg_pulse), .pwm_out(pwm_a), .frame_tick(ft_a), .at_target(at_a)
  );

  servo_pwm_core #(
    .NUM_CH(NCH), .CNT_W(CNT_W), .PULSE_MIN(P_MIN), .PULSE_MAX(P_MAX),
    .PULSE_CENTER(CENTER_B), .SLEW_STEP(SLEW_B)
  ) dut_b (
    .clock(clock), .reset(reset), .reg_enable(reg_enable), .reg_period(reg_period),
    .reg_pulse(reg_pulse), .pwm_out(pwm_b), .frame_tick(ft_b), .at_target(at_b)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int p);
    if (p < P_MIN) return P_MIN;
    if (p > P_MAX) return P_MAX;
    return p;
  endfunction

  // Model: at each frame start, move cur toward the clamped target and
  // lay out the whole frame's expected outputs.
  task automatic build_frame();
    int p, tgt, d, slew;
    logic [1:0] pw [2];
    logic [1:0] at [2];
    logic       first;
    p = int'(reg_period);
    for (int i = 0; i < 2; i++) begin
      slew = (i == 0) ? 0 : SLEW_B;
      for (int k = 0; k < NCH; k++) begin
        tgt = clamp(int'(reg_pulse[k*CNT_W +: CNT_W]));
        d = tgt - model_cur[i][k];
        if (slew == 0 || (d <= slew && d >= -slew)) model_cur[i][k] = tgt;
        else if (d > 0) model_cur[i][k] = model_cur[i][k] + slew;
        else            model_cur[i][k] = model_cur[i][k] - slew;
        at[i][k] = (model_cur[i][k] == tgt);
      end
    end
    frame_len = (p == 0) ? 1 : p;
    for (int pos = 0; pos < frame_len; pos++) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < NCH; k++)
          pw[i][k] = reg_enable[k] && (p != 0) && (pos < model_cur[i][k]);
      first = (pos == 0);
      exp_q.push_back({at[1], first, pw[1], at[0], first, pw[0]});
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back('0);
    frame_len = 1;
    for (int k = 0; k < NCH; k++) begin
      model_cur[0][k] = CENTER_A;
      model_cur[1][k] = CENTER_B;
    end
  endtask

  task automatic sample_check();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    last_pos = frame_len - exp_q.size() - 1;
    check("a_pwm",  32'(pwm_a), 32'(e[1:0]));
    check("a_tick", 32'(ft_a),  32'(e[2]));
    check("a_at",   32'(at_a),  32'(e[4:3]));
    check("b_pwm",  32'(pwm_b), 32'(e[6:5]));
    check("b_tick", 32'(ft_b),  32'(e[7]));
    check("b_at",   32'(at_b),  32'(e[9:8]));
  endtask

  // Driver
  task automatic drive();
    reg_period = CNT_W'(nxt_period);
    reg_enable = nxt_en;
    reg_pulse  = {CNT_W'(nxt_pulse[1]), CNT_W'(nxt_pulse[0])};
  endtask

  task automatic cycle();
    sample_check();
    drive();
    if (exp_q.size() == 0) build_frame();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock);
      cycle();
    end
  endtask

  task automatic wait_pos(input int p);
    int budget = 0;
    do begin
      @(negedge clock);
      cycle();
      budget++;
    end while (last_pos != p && budget < 1000);
    if (budget >= 1000) check("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic async_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_pwm_a",  32'(pwm_a), 32'd0);
    check("rst_pwm_b",  32'(pwm_b), 32'd0);
    check("rst_tick_a", 32'(ft_a),  32'd0);
    check("rst_at_b",   32'(at_b),  32'd0);
    repeat (2) @(negedge clock);
    model_reset();
    reset = 1'b0;
    cycle();
  endtask

  initial begin
    nxt_period   = 100;
    nxt_pulse[0] = 30;
    nxt_pulse[1] = 5;
    nxt_en       = 2'b11;
    drive();
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    cycle();

    run(300);                     // nominal frames, channel 1 clamped low
    nxt_pulse[1] = 90;
    run(300);                     // channel 1 clamped high
    wait_pos(40);
    nxt_pulse[0] = 50;            // mid-frame write
    run(250);

    nxt_period = 0;
    run(30);
    nxt_period   = 20;
    nxt_pulse[0] = 30;            // pulse exceeds period
    run(100);

    nxt_period   = 100;
    nxt_pulse[0] = 60;
    run(150);
    wait_pos(49);
    nxt_pulse[0] = 35;
    async_reset();                // slew from center after reset
    run(450);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 14) == 0) begin
        case ($urandom_range(0, 4))
          0: nxt_period = $urandom_range(0, 3);
          1: nxt_period = $urandom_range(4, 40);
          2: nxt_pulse[0] = $urandom_range(0, 80);
          3: nxt_pulse[1] = $urandom_range(0, 80);
          default: nxt_en = 2'($urandom_range(0, 3));
        endcase
      end
      if (c == 700) async_reset();
      else run(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_pwm_core.md
Name: servo_pwm_core

Overview:
Multi-channel servo PWM generator that sits directly downstream of the servo AXI4-Lite register slave. It consumes the slave's four 32-bit registers (control, period, channel-0 pulse, channel-1 pulse) and drives the pan/tilt servo pins. The core does the following:
- latches register values into shadow registers at frame boundaries, so output pulses are never glitched;
- clamps each target pulse width to a safe range;
- slew-limits each channel's pulse width per frame, so the servos track colour-detect targets smoothly.

Parameters:
NUM_CH, 2, number of servo channels.
CNT_W, 24, width of the tick counter and of the period/pulse values.
PULSE_MIN, 100000, minimum allowed pulse width in ticks (1 ms at 100 MHz).
PULSE_MAX, 200000, maximum allowed pulse width in ticks (2 ms).
PULSE_CENTER, 150000, pulse width of each channel after reset.
SLEW_STEP, 2000, maximum change of pulse width per frame, in ticks; 0 disables slew limiting.

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  asynchronous, active-high reset.
reg_enable  in  NUM_CH  per-channel enable, taken from control register bits [NUM_CH-1:0].
reg_period  in  CNT_W  frame period in ticks (20 ms = 2000000 at 100 MHz).
reg_pulse  in  NUM_CH*CNT_W  target pulse width per channel; channel k occupies bits [k*CNT_W +: CNT_W].
pwm_out  out  NUM_CH  servo drive pins.
frame_tick  out  1  one-cycle pulse on the first cycle of each frame.
at_target  out  NUM_CH  high when the channel's current pulse width equals its clamped target.

Behaviour:
- Reset values: pwm_out=0, frame_tick=0, at_target=0, tick counter cnt=0, shadow period=0, shadow enables=0, cur[k]=PULSE_CENTER.
- Frame counter:
  - cnt counts from 0 to shadow_period-1, then wraps to 0.
  - The boundary condition is (cnt==shadow_period-1) or (shadow_period==0).
  - When shadow_period==0, cnt is held at 0 and every cycle is a boundary. After reset the core therefore loads the register values on the first clock.
  - A shadow_period of 1 is legal: every cycle is a boundary.
- On the cycle the boundary condition holds, the following registered updates take effect on the next edge:
  - shadow_period <= reg_period; shadow_en <= reg_enable; cnt <= 0; frame_tick <= 1.
  - For each channel, tgt = clamp(reg_pulse[k], PULSE_MIN, PULSE_MAX), computed combinationally on unsigned CNT_W values.
  - Slew rule when SLEW_STEP==0: cur <= tgt.
  - Slew rule when SLEW_STEP>0:
    - if |tgt-cur| <= SLEW_STEP, cur <= tgt;
    - else if tgt > cur, cur <= cur+SLEW_STEP;
    - else cur <= cur-SLEW_STEP.
  - No overflow is possible, because cur and tgt both lie in [PULSE_MIN, PULSE_MAX].
  - A disabled channel still slews cur.
- frame_tick is 0 on all cycles other than the one following a boundary.
- pwm_out[k] is registered: pwm_out[k] <= shadow_en[k] && (cnt_next < cur_next[k]).
  - This means pwm_out rises on the same edge that frame_tick rises.
  - Latency from a boundary to the output reflecting new values is exactly 1 cycle.
  - If cur[k] >= shadow_period, the output stays high for the whole frame (no low gap).
  - When shadow_period==0, all outputs are 0.
- at_target[k] is registered: at_target[k] <= (cur_next[k] == tgt[k]). It is updated only at boundaries and holds between them.
- Register writes mid-frame (to any of reg_period, reg_pulse, reg_enable) have no effect until the next boundary.
- Reset asserted mid-frame: all state returns to its reset values asynchronously. pwm_out drops to 0 immediately, with no clock needed.
- Simultaneous events (a register change on the same cycle as a boundary): the value sampled on that boundary cycle is the one used.

Decomposition:
- Shared package servo_pkg contains:
  - localparams for the CNT_W default, PULSE_MIN, PULSE_MAX, PULSE_CENTER and SLEW_STEP;
  - typedef pulse_t (logic [CNT_W-1:0]);
  - function clamp_pulse().
- Sub-module servo_slew_channel, instantiated NUM_CH times in a generate loop:
  - inputs: clock, reset, boundary, enable, target, shared cnt_next;
  - outputs: pwm, at_target.
- The frame counter and shadow period stay in servo_pwm_core.

Test Plan:
1. Reset, then reg_period=100, reg_pulse[0]=30, all enables=1, PULSE_MIN=10, PULSE_MAX=60, SLEW_STEP=0 -> frame_tick fires every 100 cycles; pwm_out[0] is high for exactly 30 cycles per frame, starting on the frame_tick edge; at_target[0]=1 after the first boundary.
2. Clamp: with the same settings, reg_pulse[1]=5, then later reg_pulse[1]=90 -> high time is 10 cycles, then 60 cycles.
3. Slew: SLEW_STEP=4, PULSE_CENTER=20, reg_pulse[0]=35 -> high times per frame are 24, 28, 32, 35; at_target[0] is 0 for the first three frames and 1 from the fourth.
4. Mid-frame write: change reg_pulse[0] from 30 to 50 at cnt=40 -> the current frame keeps a 30-cycle high time; the next frame is 50 cycles.
5. Period edge cases: reg_period=0 -> pwm_out stays 0 and frame_tick is high every cycle. reg_period=20 with cur=30 -> pwm_out is constantly high across frames.
6. Async reset at cnt=50 with pwm_out high -> pwm_out=0 before the next clock edge; after release, cur=PULSE_CENTER and loading resumes on the first clock.
